// File: rtl/slot_demux_collector.sv
// rtl/slot_demux_collector.sv - two-channel slot demultiplexer assembling 4-bit words from a shared slot select
module slot_demux_collector (
    input  logic       clk,
    input  logic       rst,
    input  logic       d1,
    input  logic       d2,
    input  logic [1:0] s,
    input  logic       e1,
    input  logic       e2,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic       v1,
    output logic       v2,
    output logic       err1,
    output logic       err2
);

    localparam logic IDLE = 1'b0;
    localparam logic RUN  = 1'b1;

    // Index 0 is channel 1, index 1 is channel 2; the channels share only s.
    logic [1:0]      d_w;
    logic [1:0]      smp;
    logic [1:0]      state_r, state_nx;
    logic [1:0][1:0] exp_r, exp_nx;
    logic [1:0][3:0] sh_r, sh_nx;
    logic [1:0][3:0] q_r, q_nx;
    logic [1:0]      v_r, v_nx;
    logic [1:0]      err_r, err_nx;

    assign d_w = {d2, d1};
    assign smp = ~{e2, e1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= {IDLE, IDLE};
            exp_r   <= '0;
            sh_r    <= '0;
            q_r     <= '0;
            v_r     <= '0;
            err_r   <= '0;
        end else begin
            state_r <= state_nx;
            exp_r   <= exp_nx;
            sh_r    <= sh_nx;
            q_r     <= q_nx;
            v_r     <= v_nx;
            err_r   <= err_nx;
        end
    end

    always_comb begin
        state_nx = state_r;
        for (int i = 0; i < 2; i++) begin
            if (smp[i]) begin
                if (state_r[i] == IDLE) begin
                    if (s == 2'd0)
                        state_nx[i] = RUN;
                end else if (s == exp_r[i]) begin
                    if (s == 2'd3)
                        state_nx[i] = IDLE;
                end else begin
                    state_nx[i] = (s == 2'd0) ? RUN : IDLE;
                end
            end
        end
    end

    always_comb begin
        exp_nx = exp_r;
        sh_nx  = sh_r;
        q_nx   = q_r;
        v_nx   = '0;
        err_nx = '0;
        for (int i = 0; i < 2; i++) begin
            if (smp[i]) begin
                if (state_r[i] == IDLE) begin
                    if (s == 2'd0) begin
                        sh_nx[i][0] = d_w[i];
                        exp_nx[i]   = 2'd1;
                    end
                end else if (s == exp_r[i]) begin
                    if (s == 2'd3) begin
                        // Shadow is left as-is; the next frame overwrites it slot by slot.
                        q_nx[i] = {d_w[i], sh_r[i][2:0]};
                        v_nx[i] = 1'b1;
                    end else begin
                        sh_nx[i][s] = d_w[i];
                        exp_nx[i]   = exp_r[i] + 2'd1;
                    end
                end else begin
                    err_nx[i] = 1'b1;
                    if (s == 2'd0) begin
                        sh_nx[i][0] = d_w[i];
                        exp_nx[i]   = 2'd1;
                    end
                end
            end
        end
    end

    assign q1   = q_r[0];
    assign q2   = q_r[1];
    assign v1   = v_r[0];
    assign v2   = v_r[1];
    assign err1 = err_r[0];
    assign err2 = err_r[1];

endmodule

// File: tb/tb_slot_demux_collector.sv
// tb/tb_slot_demux_collector.sv - directed self-checking bench for slot_demux_collector
module tb_slot_demux_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       d1, d2;
    logic [1:0] s;
    logic       e1, e2;
    logic [3:0] q1, q2;
    logic       v1, v2, err1, err2;

    int n_cmp = 0;
    int n_bad = 0;

    slot_demux_collector dut (
        .clk  (clk),
        .rst  (rst),
        .d1   (d1),
        .d2   (d2),
        .s    (s),
        .e1   (e1),
        .e2   (e2),
        .q1   (q1),
        .q2   (q2),
        .v1   (v1),
        .v2   (v2),
        .err1 (err1),
        .err2 (err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic a1, input logic a2, input logic [1:0] ss,
                        input logic n1, input logic n2);
        d1 = a1;
        d2 = a2;
        s  = ss;
        e1 = n1;
        e2 = n2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        d1 = 1'b1; d2 = 1'b1; s = 2'd0; e1 = 1'b0; e2 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_q1", q1, 4'h0);
        chk("rst_q2", q2, 4'h0);
        chk("rst_v", {2'b00, v1, v2}, 4'h0);
        chk("rst_err", {2'b00, err1, err2}, 4'h0);
        rst = 1'b0;
        step(1'b0, 1'b0, 2'd1, 1'b1, 1'b1);
        chk("post_rst_q1", q1, 4'h0);
        chk("post_rst_flags", {v1, v2, err1, err2}, 4'h0);

        // Channel 1 frame 1,0,1,1; channel 2 disabled
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
        chk("f1_no_v_early", {3'b000, v1}, 4'h0);
        step(1'b1, 1'b1, 2'd3, 1'b0, 1'b1);
        chk("f1_q1", q1, 4'b1101);
        chk("f1_v1", {3'b000, v1}, 4'h1);
        chk("f1_q2", q2, 4'h0);
        chk("f1_v2", {3'b000, v2}, 4'h0);
        step(1'b0, 1'b0, 2'd0, 1'b1, 1'b1);
        chk("f1_v1_drop", {3'b000, v1}, 4'h0);
        chk("f1_q1_hold", q1, 4'b1101);

        // Back-to-back frames
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("b2b_q1_a", q1, 4'b1111);
        chk("b2b_v1_a", {3'b000, v1}, 4'h1);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("b2b_v1_gap", {v1, err1, 2'b00}, 4'h0);
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("b2b_q1_b", q1, 4'b0100);
        chk("b2b_v1_b", {3'b000, v1}, 4'h1);

        // Order violation 0,1,3 then a clean frame 0,1,0,0
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("ov_err1", {3'b000, err1}, 4'h1);
        chk("ov_v1", {3'b000, v1}, 4'h0);
        chk("ov_q1", q1, 4'b0100);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("ov_err1_drop", {3'b000, err1}, 4'h0);
        step(1'b1, 1'b0, 2'd1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("ov_q1_new", q1, 4'b0010);
        chk("ov_v1_new", {3'b000, v1}, 4'h1);

        // Restart on slot 0 plus an enable gap
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("rs_err1", {3'b000, err1}, 4'h1);
        chk("rs_q1_hold", q1, 4'b0010);
        step(1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        chk("rs_err1_drop", {3'b000, err1}, 4'h0);
        step(1'b0, 1'b0, 2'd3, 1'b1, 1'b1);
        chk("rs_gap_flags", {v1, err1, 2'b00}, 4'h0);
        step(1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2'd3, 1'b0, 1'b1);
        chk("rs_q1", q1, 4'b1101);
        chk("rs_v1", {v1, err1, 2'b00}, 4'b1000);

        // Both channels together, different data
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 2'd3, 1'b0, 1'b0);
        chk("dual_q1", q1, 4'b0001);
        chk("dual_q2", q2, 4'b0110);
        chk("dual_v", {v1, v2, err1, err2}, 4'b1100);

        // Reset mid-frame, with a sample offered during reset
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        rst = 1'b0;
        chk("mid_rst_q1", q1, 4'h0);
        chk("mid_rst_q2", q2, 4'h0);
        step(1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        chk("mid_s2_flags", {v1, v2, err1, err2}, 4'h0);
        step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
        chk("mid_s3_flags", {v1, v2, err1, err2}, 4'h0);
        chk("mid_q1_final", q1, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slot_demux_collector.md
# slot_demux_collector

Receiving end of a two-channel time-multiplexed bit link driven by a dual 4-to-1 selector whose select lines are stepped by a slot counter. Samples each serial line once per slot, demultiplexes the bit into slot position `s`, and publishes a complete 4-bit word per channel once slots 0..3 have arrived in order. Sits between the multiplexed backplane lines and the parallel consumers; channels share the slot select but are otherwise independent.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `d1`  in  1  serial data, channel 1.
- `d2`  in  1  serial data, channel 2.
- `s`  in  2  current slot index, shared by both channels.
- `e1`  in  1  channel 1 sample enable, active-low; high = channel 1 ignores this cycle.
- `e2`  in  1  channel 2 sample enable, active-low.
- `q1`  out  4  last published word, channel 1; bit `k` came from slot `k`.
- `q2`  out  4  last published word, channel 2.
- `v1`  out  1  one-cycle pulse: `q1` just updated.
- `v2`  out  1  one-cycle pulse: `q2` just updated.
- `err1`  out  1  one-cycle pulse: channel 1 slot-order violation.
- `err2`  out  1  one-cycle pulse: channel 2 slot-order violation.

## Operation
- Each channel `n` holds: state {IDLE, RUN}, expected slot `exp` (2 bits), shadow word `sh` (4 bits), published `q`, flags `v`, `err`.
- "Sample" for channel `n`: rising edge with `rst`=0 and `en`=0.
- Without a sample: state, `exp`, `sh`, `q` hold; `v`, `err` return to 0.
- IDLE, sample with `s`=0: `sh[0]`<=`d`, `exp`<=1, go RUN.
- IDLE, sample with `s`≠0: ignored, stay IDLE, no error.
- RUN, sample with `s`=`exp`, `s`<3: `sh[s]`<=`d`, `exp`<=`exp`+1.
- RUN, sample with `s`=`exp`=3: `q`<={`d`,`sh[2:0]`}, `v`<=1, go IDLE. The shadow is not cleared.
- RUN, sample with `s`≠`exp`: `err`<=1, partial word discarded, `q` unchanged.
  - If `s`=0, restart: `sh[0]`<=`d`, `exp`<=1, stay RUN.
  - Otherwise go IDLE.
- Back-to-back frames: the slot-0 sample directly after a publish is accepted from IDLE, so frames every 4 samples are lossless.
- Enable gaps inside a frame are allowed. A channel may pause for any number of cycles between slots without error.
- `v` and `err` are never both 1 in the same cycle for one channel.
- Channels never interact. `e1`/`e2` independently gate the same `s`.

## Timing
- Reset (`rst`=1 at an edge): `q1`=`q2`=0, `v1`=`v2`=0, `err1`=`err2`=0; states IDLE, `exp`=0, `sh`=0.
- Reset has priority over any sample in the same cycle.
- Reset mid-frame discards the partial word.
- All outputs are registered; nothing is combinational from inputs.
- Latency: `q` and `v` update on the same edge that samples slot 3. `v` is high for exactly the following cycle.
- Minimum frame length is 4 consecutive sampling cycles, giving a throughput of 1 word per 4 cycles per channel.
- `err` asserts on the edge that samples the bad slot and stays high one cycle.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `d1`=`d2`=1 and `e1`=`e2`=0 -> `q1`=`q2`=0, `v`=`err`=0 after release.
- In-order frame, channel 1: `e1`=0, slots 0..3 with `d1`=1,0,1,1 -> `q1`=4'b1101, `v1` high one cycle after the slot-3 edge. Channel 2 with `e2`=1 -> `q2`=0, `v2` never pulses.
- Back-to-back frames: 8 consecutive samples with `d1` pattern 1,1,1,1,0,0,1,0 -> `q1`=4'b1111 then 4'b0100, `v1` pulses at cycles 4 and 8.
- Order violation: slots 0,1,3 -> `err1` pulse on the slot-3 edge, `q1` unchanged. Then slots 0..3 with `d1`=0,1,0,0 -> `q1`=4'b0010, `v1`=1.
- Restart and gaps: slots 0,1,0,1,2,3 with one idle cycle (`e1`=1) between slots 1 and 2 and `d1`=x,x,1,0,1,1 -> one `err1` pulse at the second slot 0, then `q1`=4'b1101.
- Reset mid-frame: slots 0,1 sampled, `rst`=1 for one cycle, then slots 2,3 sampled -> no `v1`, no `err1`, `q1`=0.
